fb_scan_arbiter: RTL and testbench

Memory-side controller for the VGA scanout path. It owns the single-port framebuffer SRAM and shares it between two requesters: display line prefetch, which fills one bank of a ping-pong line buffer with `WIDTH` pixels per line, and a CPU write port using a valid/ready handshake. Display fetch has priority. The CPU is guaranteed one memory slot every `CPU_SLOT` cycles during a fetch, and every cycle otherwise. The block sits between the `vga` timing generator and the framebuffer SRAM.

---
 rtl/fb_scan_arbiter_if.sv | 35 +++
 rtl/fb_scan_arbiter.sv | 112 +++++++++++
 tb/tb_fb_scan_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_scan_arbiter_if.sv
// Bus bundle for the framebuffer scan arbiter: line-prefetch control, CPU write
// port, SRAM port and line-buffer write port. The arbiter sits on the slave side.
interface fb_scan_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int LB_W   = 10
);
  logic              line_req;
  logic [15:0]       line_y;
  logic              line_busy;
  logic              line_err;
  logic              cpu_valid;
  logic              cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              lb_we;
  logic [LB_W-1:0]   lb_addr;
  logic [15:0]       lb_data;
  logic              lb_bank;

  modport master (
    output line_req, line_y, cpu_valid, cpu_addr, cpu_data, mem_rdata,
    input  line_busy, line_err, cpu_ready, mem_addr, mem_we, mem_wdata,
           lb_we, lb_addr, lb_data, lb_bank
  );

  modport slave (
    input  line_req, line_y, cpu_valid, cpu_addr, cpu_data, mem_rdata,
    output line_busy, line_err, cpu_ready, mem_addr, mem_we, mem_wdata,
           lb_we, lb_addr, lb_data, lb_bank
  );
endinterface

// File: rtl/fb_scan_arbiter.sv
// Framebuffer SRAM arbiter: display line prefetch into a ping-pong line buffer
// has priority; the CPU write port gets every CPU_SLOT-th cycle during a fetch.
module fb_scan_arbiter #(
  parameter int WIDTH    = 800,
  parameter int HEIGHT   = 600,
  parameter int ADDR_W   = 19,
  parameter int CPU_SLOT = 8
) (
  input logic            clk,
  input logic            res,
  fb_scan_arbiter_if.slave bus
);
  localparam int XW  = $clog2(WIDTH + 1);
  localparam int LBW = $clog2(WIDTH);
  localparam int SW  = $clog2(CPU_SLOT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [XW-1:0]       r_x;
  logic [SW-1:0]       r_slot;
  logic                r_bank;
  logic                r_err_p1;
  logic                r_lb_we_p1;
  logic [LBW-1:0]      r_lb_addr_p1;

  logic [ADDR_W+15:0]  w_prod;
  logic                w_accept;
  logic                w_slot;
  logic                w_cpu_rdy;
  logic                w_cpu_xfer;
  logic                w_rd;
  logic                w_last;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_mem_addr;

  assign w_prod     = (ADDR_W+16)'(bus.line_y) * (ADDR_W+16)'(WIDTH);
  assign w_accept   = (r_state == S_IDLE) && bus.line_req && (32'(bus.line_y) < HEIGHT);
  assign w_slot     = (r_slot == SW'(CPU_SLOT - 1));
  assign w_cpu_rdy  = (r_state != S_FETCH) || w_slot;
  // Gated by reset so no stray write reaches the SRAM while res is held low.
  assign w_cpu_xfer = bus.cpu_valid && w_cpu_rdy && res;
  assign w_rd       = (r_state == S_FETCH) && !w_cpu_xfer;
  assign w_last     = w_rd && (r_x == XW'(WIDTH - 1));
  assign w_rd_addr  = r_base + ADDR_W'(r_x);

  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FETCH;
      S_FETCH: if (w_last)   w_next = S_DRAIN;
      S_DRAIN:               w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr = bus.cpu_addr;
    if (w_rd) w_mem_addr = w_rd_addr;
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_cpu_xfer;
  assign bus.mem_wdata = bus.cpu_data;
  assign bus.cpu_ready = w_cpu_rdy;
  assign bus.line_busy = (r_state != S_IDLE);
  assign bus.line_err  = r_err_p1;
  assign bus.lb_bank   = r_bank;

  always_ff @(posedge clk) begin
    if (w_accept) r_base <= w_prod[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_x    <= '0;
      r_slot <= '0;
      r_bank <= 1'b0;
    end else if (w_accept) begin
      r_x    <= '0;
      r_slot <= '0;
      r_bank <= ~r_bank;
    end else if (r_state == S_FETCH) begin
      r_slot <= w_slot ? '0 : r_slot + SW'(1);
      if (w_rd) r_x <= r_x + XW'(1);
    end
  end

  // Stage p1: SRAM read data returns one cycle after the address; pair it with x.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_err_p1     <= 1'b0;
      r_lb_we_p1   <= 1'b0;
      r_lb_addr_p1 <= '0;
    end else begin
      r_err_p1   <= bus.line_req && (r_state != S_IDLE);
      r_lb_we_p1 <= w_rd;
      if (w_rd) r_lb_addr_p1 <= LBW'(r_x);
    end
  end

  assign bus.lb_we   = r_lb_we_p1;
  assign bus.lb_addr = r_lb_addr_p1;
  assign bus.lb_data = bus.mem_rdata;
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: per-cycle expectations for each fetch are
// queued when the fetch is planned and popped as the cycles are driven.
module tb_fb_scan_arbiter;
  localparam logic [18:0] CPU_A = 19'h12345;
  localparam logic [15:0] CPU_D = 16'h7E57;

  typedef struct packed {
    logic        req;
    logic [15:0] y;
    logic        cv;
    logic        busy;
    logic        err;
    logic        rdy;
    logic        we;
    logic [18:0] addr;
    logic        rd;
    logic        lbwe;
    logic [3:0]  lbaddr;
    logic [15:0] lbdata;
    logic        bank;
  } rec_t;

  logic clk;
  logic res;
  int   n_tests;
  int   n_fail;
  logic exp_bank;
  logic [15:0] nxt_rd;
  int   busy_cnt;
  rec_t sb[$];

  fb_scan_arbiter_if #(.ADDR_W(19), .LB_W(4)) bus ();

  fb_scan_arbiter #(.WIDTH(16), .HEIGHT(600), .ADDR_W(19), .CPU_SLOT(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [18:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic build_fetch(input logic [15:0] y, input logic cv, input int drop_at);
    rec_t        r;
    logic [18:0] base;
    int          n;
    int          k;
    int          prev_x;
    logic        prev_rd;
    logic        err_next;
    base = 19'(y) * 19'd16;
    r = '0;
    r.req = 1'b1; r.y = y; r.cv = cv; r.we = cv; r.addr = CPU_A; r.rdy = 1'b1; r.bank = exp_bank;
    sb.push_back(r);
    exp_bank = ~exp_bank;
    n = 0; k = 0; prev_x = 0; prev_rd = 1'b0; err_next = 1'b0;
    while (n < 16) begin
      r = '0;
      r.req = (k == drop_at); r.y = y; r.cv = cv; r.busy = 1'b1; r.err = err_next;
      r.rdy = (k % 4 == 3);
      r.we = cv && r.rdy;
      r.addr = r.we ? CPU_A : base + 19'(n);
      r.rd = !r.we;
      r.lbwe = prev_rd; r.lbaddr = 4'(prev_x); r.lbdata = pix(base + 19'(prev_x));
      r.bank = exp_bank;
      sb.push_back(r);
      err_next = r.req;
      prev_rd = r.rd;
      if (r.rd) begin
        prev_x = n;
        n++;
      end
      k++;
    end
    r = '0;
    r.cv = cv; r.busy = 1'b1; r.err = err_next; r.rdy = 1'b1; r.we = cv; r.addr = CPU_A;
    r.lbwe = prev_rd; r.lbaddr = 4'(prev_x); r.lbdata = pix(base + 19'(prev_x)); r.bank = exp_bank;
    sb.push_back(r);
    r = '0;
    r.rdy = 1'b1; r.addr = CPU_A; r.bank = exp_bank;
    sb.push_back(r);
  endtask

  task automatic run_sb();
    rec_t r;
    busy_cnt = 0;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(negedge clk);
      bus.line_req  = r.req;
      bus.line_y    = r.y;
      bus.cpu_valid = r.cv;
      bus.mem_rdata = nxt_rd;
      #2;
      chk("busy", 32'(bus.line_busy), 32'(r.busy));
      chk("err", 32'(bus.line_err), 32'(r.err));
      chk("ready", 32'(bus.cpu_ready), 32'(r.rdy));
      chk("mem_we", 32'(bus.mem_we), 32'(r.we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(r.addr));
      chk("lb_we", 32'(bus.lb_we), 32'(r.lbwe));
      chk("lb_bank", 32'(bus.lb_bank), 32'(r.bank));
      if (r.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(CPU_D));
      if (r.lbwe) begin
        chk("lb_addr", 32'(bus.lb_addr), 32'(r.lbaddr));
        chk("lb_data", 32'(bus.lb_data), 32'(r.lbdata));
      end
      if (bus.line_busy) busy_cnt++;
      nxt_rd = r.rd ? pix(r.addr) : 16'hDEAD;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    exp_bank = 1'b0;
    nxt_rd = 16'h0;
    res = 1'b0;
    bus.line_req  = 1'($urandom);
    bus.line_y    = 16'($urandom_range(0, 100));
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 19'($urandom);
    bus.cpu_data  = 16'($urandom);
    bus.mem_rdata = 16'($urandom);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus.line_busy), 32'd0);
    chk("rst_err", 32'(bus.line_err), 32'd0);
    chk("rst_lb_we", 32'(bus.lb_we), 32'd0);
    chk("rst_lb_addr", 32'(bus.lb_addr), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_ready", 32'(bus.cpu_ready), 32'd1);
    chk("rst_bank", 32'(bus.lb_bank), 32'd0);

    @(negedge clk);
    bus.line_req = 1'b0; bus.line_y = 16'd0; bus.cpu_valid = 1'b0;
    bus.cpu_addr = CPU_A; bus.cpu_data = CPU_D;
    res = 1'b1;

    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_addr = 19'h00010; bus.cpu_data = 16'hABCD;
    #2;
    chk("idle_ready", 32'(bus.cpu_ready), 32'd1);
    chk("idle_we", 32'(bus.mem_we), 32'd1);
    chk("idle_addr", 32'(bus.mem_addr), 32'h00010);
    chk("idle_wdata", 32'(bus.mem_wdata), 32'hABCD);
    @(negedge clk);
    bus.cpu_valid = 1'b0; bus.cpu_addr = CPU_A; bus.cpu_data = CPU_D;

    build_fetch(16'd2, 1'b0, -1);
    run_sb();
    chk("busy_len_nocpu", 32'(busy_cnt), 32'd17);

    build_fetch(16'd2, 1'b1, -1);
    run_sb();
    chk("busy_len_cpu", 32'(busy_cnt), 32'd22);

    build_fetch(16'd7, 1'b0, 5);
    run_sb();
    chk("busy_len_drop", 32'(busy_cnt), 32'd17);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.line_req = 1'b1; bus.line_y = 16'(600 + i);
      @(negedge clk);
      bus.line_req = 1'b0;
      #2;
      chk("oor_busy", 32'(bus.line_busy), 32'd0);
      chk("oor_err", 32'(bus.line_err), 32'd0);
    end

    @(negedge clk);
    bus.line_req = 1'b1; bus.line_y = 16'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.line_req = 1'b0;
    end
    @(negedge clk);
    res = 1'b0;
    #2;
    chk("mid_rst_busy", 32'(bus.line_busy), 32'd0);
    chk("mid_rst_lb_we", 32'(bus.lb_we), 32'd0);
    chk("mid_rst_bank", 32'(bus.lb_bank), 32'd0);
    chk("mid_rst_ready", 32'(bus.cpu_ready), 32'd1);
    @(negedge clk);
    #2;
    chk("mid_rst_lb_we2", 32'(bus.lb_we), 32'd0);
    chk("mid_rst_lb_addr", 32'(bus.lb_addr), 32'd0);
    @(negedge clk);
    res = 1'b1;
    exp_bank = 1'b0;

    build_fetch(16'd3, 1'b0, -1);
    run_sb();
    chk("busy_len_after_rst", 32'(busy_cnt), 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
